// File: rtl/memory_controller.sv
// memory_controller
//   Responder for the load/store buffer and the instruction-fetch port. Serialises
//   store, load and fetch requests (priority store > load > fetch) onto a single
//   byte-wide RAM/IO bus and returns one finish/done pulse per request.
//
//   Ports
//     clk_in, rst_in (sync, active-low), rdy_in (low = pause), roll_back (flush)
//     mem_din / mem_dout / mem_a / mem_wr   byte bus to RAM/IO
//     io_buffer_full                        IO write buffer back-pressure
//     ifetch_req/addr -> ifetch_done/data   4-byte instruction fetch
//     lsb_load/load_address/op_type_load -> finish_load/data_load
//     lsb_store/store_address/data_store/op_type_store -> finish_store
//
//   Timing (RAM_RD_LAT = 1): a read accepted in cycle 0 issues bytes in cycles
//   1..N and pulses finish in cycle N+2; a write drives bytes in cycles 1..N and
//   pulses finish in cycle N+1. RAM_RD_LAT must be >= 1.
module memory_controller #(
  parameter logic [31:0] IO_BASE    = 32'h30000,
  parameter int unsigned RAM_RD_LAT = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        ifetch_req,
  input  logic [31:0] ifetch_addr,
  output logic        ifetch_done,
  output logic [31:0] ifetch_data,
  input  logic        lsb_load,
  input  logic [31:0] load_address,
  input  logic [2:0]  op_type_load,
  output logic        finish_load,
  output logic [31:0] data_load,
  input  logic        lsb_store,
  input  logic [31:0] store_address,
  input  logic [31:0] data_store,
  input  logic [2:0]  op_type_store,
  output logic        finish_store
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

  state_t            state;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf;
  logic [2:0]        len_q;
  logic [2:0]        issue_cnt;
  logic [2:0]        cap_cnt;
  logic [1:0]        rsize_q;
  logic              sext_q;
  logic              is_fetch;
  logic              mem_wr_q;
  logic              resync;
  // bit 0: mem_a carries a valid read this cycle; bit RAM_RD_LAT: mem_din valid now
  logic [RAM_RD_LAT:0] inflight;

  logic        busy_out;
  logic [2:0]  store_len;
  logic [2:0]  load_len;
  logic [31:0] cap_word;
  logic [31:0] load_word;
  logic        last_cap;

  // Writes must never reach the bus while paused.
  assign mem_wr = mem_wr_q & rdy_in;

  always_comb begin
    busy_out = finish_load | finish_store | ifetch_done;

    case (op_type_store)
      3'b000:  store_len = 3'd1;
      3'b001:  store_len = 3'd2;
      default: store_len = 3'd4;
    endcase

    case (op_type_load[1:0])
      2'b00:   load_len = 3'd1;
      2'b01:   load_len = 3'd2;
      default: load_len = 3'd4;
    endcase

    cap_word = rbuf;
    cap_word[8*cap_cnt[1:0] +: 8] = mem_din;

    case (rsize_q)
      2'b00:   load_word = sext_q ? {{24{cap_word[7]}}, cap_word[7:0]}
                                  : {24'h0, cap_word[7:0]};
      2'b01:   load_word = sext_q ? {{16{cap_word[15]}}, cap_word[15:0]}
                                  : {16'h0, cap_word[15:0]};
      default: load_word = cap_word;
    endcase

    last_cap = inflight[RAM_RD_LAT] && ((cap_cnt + 3'd1) == len_q);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf         <= '0;
      len_q        <= '0;
      issue_cnt    <= '0;
      cap_cnt      <= '0;
      rsize_q      <= '0;
      sext_q       <= 1'b0;
      is_fetch     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resync       <= 1'b0;
      inflight     <= '0;
      mem_a        <= '0;
      mem_dout     <= '0;
      finish_load  <= 1'b0;
      finish_store <= 1'b0;
      ifetch_done  <= 1'b0;
      data_load    <= '0;
      ifetch_data  <= '0;
    end else if (!rdy_in) begin
      // Everything frozen; remember that the byte in flight cannot be trusted.
      resync <= 1'b1;
    end else begin
      resync       <= 1'b0;
      finish_load  <= 1'b0;
      finish_store <= 1'b0;
      ifetch_done  <= 1'b0;

      case (state)
        IDLE: begin
          if (!busy_out) begin
            if (lsb_store) begin
              addr_q  <= store_address;
              wdata_q <= data_store;
              len_q   <= store_len;
              if (store_address >= IO_BASE && io_buffer_full) begin
                state <= IO_WAIT;
              end else begin
                state     <= WRITE;
                mem_wr_q  <= 1'b1;
                mem_a     <= store_address;
                mem_dout  <= data_store[7:0];
                issue_cnt <= 3'd1;
              end
            end else if (!roll_back && (lsb_load || ifetch_req)) begin
              is_fetch  <= !lsb_load;
              addr_q    <= lsb_load ? load_address : ifetch_addr;
              len_q     <= lsb_load ? load_len : 3'd4;
              rsize_q   <= lsb_load ? op_type_load[1:0] : 2'b10;
              sext_q    <= lsb_load ? !op_type_load[2] : 1'b0;
              mem_a     <= lsb_load ? load_address : ifetch_addr;
              rbuf      <= '0;
              issue_cnt <= 3'd1;
              cap_cnt   <= '0;
              inflight  <= {{RAM_RD_LAT{1'b0}}, 1'b1};
              state     <= READ;
            end
          end
        end

        IO_WAIT: begin
          if (!io_buffer_full) begin
            state     <= WRITE;
            mem_wr_q  <= 1'b1;
            mem_a     <= addr_q;
            mem_dout  <= wdata_q[7:0];
            issue_cnt <= 3'd1;
          end
        end

        WRITE: begin
          if (issue_cnt == len_q) begin
            state        <= IDLE;
            mem_wr_q     <= 1'b0;
            mem_a        <= '0;
            mem_dout     <= '0;
            finish_store <= 1'b1;
          end else begin
            mem_a     <= addr_q + {29'd0, issue_cnt};
            mem_dout  <= wdata_q[8*issue_cnt[1:0] +: 8];
            issue_cnt <= issue_cnt + 3'd1;
          end
        end

        READ: begin
          if (roll_back) begin
            state    <= IDLE;
            mem_a    <= '0;
            inflight <= '0;
          end else if (resync) begin
            // Restart the byte pipeline at the first byte not yet captured.
            mem_a     <= addr_q + {29'd0, cap_cnt};
            issue_cnt <= cap_cnt + 3'd1;
            inflight  <= {{RAM_RD_LAT{1'b0}}, 1'b1};
          end else if (last_cap) begin
            state       <= IDLE;
            mem_a       <= '0;
            inflight    <= '0;
            finish_load <= !is_fetch;
            ifetch_done <= is_fetch;
            if (is_fetch) ifetch_data <= cap_word;
            else          data_load   <= load_word;
          end else begin
            if (inflight[RAM_RD_LAT]) begin
              rbuf    <= cap_word;
              cap_cnt <= cap_cnt + 3'd1;
            end
            if (issue_cnt < len_q) begin
              mem_a     <= addr_q + {29'd0, issue_cnt};
              issue_cnt <= issue_cnt + 3'd1;
              inflight  <= {inflight[RAM_RD_LAT-1:0], 1'b1};
            end else begin
              inflight  <= {inflight[RAM_RD_LAT-1:0], 1'b0};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: behavioural RAM plus an expected-memory
// model; loads are predicted from the model with plain byte arithmetic.
module tb_memory_controller;

  localparam logic [31:0] IO_BASE = 32'h30000;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        ifetch_req, ifetch_done;
  logic [31:0] ifetch_addr, ifetch_data;
  logic        lsb_load, finish_load;
  logic [31:0] load_address, data_load;
  logic [2:0]  op_type_load;
  logic        lsb_store, finish_store;
  logic [31:0] store_address, data_store;
  logic [2:0]  op_type_store;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram   [logic [31:0]];
  logic [7:0] model [logic [31:0]];

  always #5 clk_in = ~clk_in;

  memory_controller #(.IO_BASE(IO_BASE), .RAM_RD_LAT(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
    .ifetch_done(ifetch_done), .ifetch_data(ifetch_data),
    .lsb_load(lsb_load), .load_address(load_address), .op_type_load(op_type_load),
    .finish_load(finish_load), .data_load(data_load),
    .lsb_store(lsb_store), .store_address(store_address), .data_store(data_store),
    .op_type_store(op_type_store), .finish_store(finish_store)
  );

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return model.exists(a) ? model[a] : 8'h00;
  endfunction

  // RAM: one-cycle read latency, write on mem_wr.
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  function automatic int nbytes(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(op); i++)
      v = v | (32'(model_rd(a + 32'(i))) << (8 * i));
    if (op == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (op == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a]   = b;
    model[a] = b;
  endtask

  task automatic do_read(input bit fetch, input logic [31:0] a, input logic [2:0] op,
                         input int pause_at, input int pause_len, input string tag);
    logic [31:0] exp, got;
    logic [2:0]  eop;
    int n, cnt, wrong;
    bit done;
    eop   = fetch ? 3'b010 : op;
    exp   = model_load(a, eop);
    n     = nbytes(eop);
    got   = 'x;
    cnt   = 0;
    wrong = 0;
    done  = 1'b0;
    if (fetch) begin ifetch_req = 1'b1; ifetch_addr = a; end
    else begin lsb_load = 1'b1; load_address = a; op_type_load = op; end
    while (!done && cnt < 60) begin
      step;
      cnt++;
      if (pause_len > 0 && cnt == pause_at) rdy_in = 1'b0;
      if (pause_len > 0 && cnt == pause_at + pause_len) rdy_in = 1'b1;
      #1;
      if (finish_store || (fetch ? finish_load : ifetch_done)) wrong++;
      if (fetch ? ifetch_done : finish_load) begin
        done = 1'b1;
        got  = fetch ? ifetch_data : data_load;
        ifetch_req = 1'b0;
        lsb_load   = 1'b0;
      end
    end
    rdy_in = 1'b1;
    ifetch_req = 1'b0;
    lsb_load   = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (pause_len == 0) chk({tag, "_latency"}, 32'(cnt), 32'(n + 2));
    chk({tag, "_data"}, got, exp);
    chk({tag, "_wrong_port"}, 32'(wrong), 32'd0);
    step;
    chk({tag, "_pulse_width"}, 32'(fetch ? ifetch_done : finish_load), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d,
                          input int io_wait, input int rb_at,
                          input int pause_at, input int pause_len, input string tag);
    int n, w, cnt, idx, nwr;
    bit done;
    n    = nbytes(op);
    w    = (a >= IO_BASE) ? io_wait : 0;
    cnt  = 0;
    nwr  = 0;
    done = 1'b0;
    lsb_store = 1'b1; store_address = a; data_store = d; op_type_store = op;
    io_buffer_full = (io_wait > 0);
    while (!done && cnt < 60) begin
      step;
      cnt++;
      if (cnt == io_wait) io_buffer_full = 1'b0;
      roll_back = (cnt == rb_at);
      if (pause_len > 0 && cnt == pause_at) rdy_in = 1'b0;
      if (pause_len > 0 && cnt == pause_at + pause_len) rdy_in = 1'b1;
      #1;
      if (!rdy_in) chk({tag, "_wr_paused"}, 32'(mem_wr), 32'd0);
      if (mem_wr) begin
        nwr++;
        if (pause_len == 0) begin
          idx = cnt - w - 1;
          chk({tag, "_wr_slot"}, 32'(idx >= 0 && idx < n), 32'd1);
          chk({tag, "_wr_addr"}, mem_a, a + 32'(idx));
          chk({tag, "_wr_data"}, 32'(mem_dout), 32'((d >> (8 * idx)) & 32'hFF));
        end
      end
      if (finish_store) begin
        done = 1'b1;
        lsb_store = 1'b0;
      end
    end
    lsb_store = 1'b0; roll_back = 1'b0; io_buffer_full = 1'b0; rdy_in = 1'b1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (pause_len == 0) chk({tag, "_latency"}, 32'(cnt), 32'(w + n + 1));
    chk({tag, "_nwrites"}, 32'(nwr), 32'(n));
    for (int i = 0; i < n; i++) model[a + 32'(i)] = 8'((d >> (8 * i)) & 32'hFF);
    step;
    chk({tag, "_pulse_width"}, 32'(finish_store), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] el, ef, gl, gf, a, d;
    logic [2:0]  ops [5];
    int ord [$];
    int code, cnt, sum, seen;

    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0; io_buffer_full = 1'b0;
    ifetch_req = 1'b0; ifetch_addr = '0; lsb_load = 1'b0; load_address = '0;
    op_type_load = '0; lsb_store = 1'b0; store_address = '0; data_store = '0;
    op_type_store = '0;
    repeat (3) step;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_finish_load", 32'(finish_load), 32'h0);
    chk("rst_finish_store", 32'(finish_store), 32'h0);
    chk("rst_ifetch_done", 32'(ifetch_done), 32'h0);
    chk("rst_data_load", data_load, 32'h0);
    chk("rst_ifetch_data", ifetch_data, 32'h0);
    rst_in = 1'b1;
    step;

    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    poke(32'h200, 8'h80); poke(32'h202, 8'h00); poke(32'h203, 8'h80);
    poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2);
    poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
    for (int i = 0; i < 4; i++) poke(32'h600 + 32'(i), 8'(8'h13 + 8'(i * 16)));
    for (int i = 0; i < 72; i++) poke(32'h1000 + 32'(i), 8'($urandom));

    do_read(1'b0, 32'h100, 3'b010, 0, 0, "lw_basic");
    chk("lw_basic_value", data_load, 32'h1234_5678);
    do_read(1'b0, 32'h200, 3'b000, 0, 0, "lb_neg");
    chk("lb_neg_value", data_load, 32'hFFFF_FF80);
    do_read(1'b0, 32'h200, 3'b100, 0, 0, "lbu");
    chk("lbu_value", data_load, 32'h0000_0080);
    do_read(1'b0, 32'h202, 3'b001, 0, 0, "lh_neg");
    chk("lh_neg_value", data_load, 32'hFFFF_8000);
    do_read(1'b0, 32'h202, 3'b101, 0, 0, "lhu");
    do_read(1'b0, 32'hFFFF_FFFE, 3'b010, 0, 0, "lw_wrap");
    do_read(1'b1, 32'h600, 3'b010, 0, 0, "fetch");

    do_write(32'h300, 3'b001, 32'hAABB_CCDD, 0, 0, 0, 0, "sh_basic");
    do_read(1'b0, 32'h300, 3'b101, 0, 0, "sh_readback");
    chk("sh_readback_value", data_load, 32'h0000_CCDD);
    do_write(IO_BASE, 3'b000, 32'h0000_005A, 5, 0, 0, 0, "sb_io_wait");
    do_read(1'b0, IO_BASE, 3'b100, 0, 0, "io_readback");
    do_write(32'h400, 3'b000, 32'h0000_0077, 3, 0, 0, 0, "sb_ram_full_ignored");
    do_write(32'h500, 3'b010, 32'h0BAD_F00D, 0, 2, 0, 0, "sw_rollback");
    do_read(1'b0, 32'h500, 3'b010, 0, 0, "sw_rb_readback");
    do_write(32'h700, 3'b010, 32'h8765_4321, 0, 0, 2, 3, "sw_pause");
    do_read(1'b0, 32'h700, 3'b010, 0, 0, "sw_pause_readback");
    do_read(1'b0, 32'h100, 3'b010, 3, 3, "lw_pause");
    do_read(1'b1, 32'h600, 3'b010, 2, 2, "fetch_pause");

    // Roll-back three cycles into a LW: aborted, no pulse.
    lsb_load = 1'b1; load_address = 32'h100; op_type_load = 3'b010;
    repeat (3) step;
    roll_back = 1'b1; lsb_load = 1'b0;
    step;
    roll_back = 1'b0;
    chk("rb_mid_idle_addr", mem_a, 32'h0);
    seen = 0;
    repeat (10) begin step; if (finish_load || ifetch_done) seen++; end
    chk("rb_mid_no_finish", 32'(seen), 32'd0);

    // Roll-back in the accept cycle cancels the accept.
    lsb_load = 1'b1; load_address = 32'h100; roll_back = 1'b1;
    step;
    lsb_load = 1'b0; roll_back = 1'b0;
    chk("rb_accept_addr", mem_a, 32'h0);
    seen = 0;
    repeat (8) begin step; if (finish_load || ifetch_done) seen++; end
    chk("rb_accept_no_finish", 32'(seen), 32'd0);

    // All three requests at once: store, then load, then fetch.
    el = model_load(32'h100, 3'b010);
    ef = model_load(32'h600, 3'b010);
    gl = 'x; gf = 'x;
    lsb_store = 1'b1; store_address = 32'h800; data_store = 32'hCAFE_F00D; op_type_store = 3'b010;
    lsb_load = 1'b1; load_address = 32'h100; op_type_load = 3'b010;
    ifetch_req = 1'b1; ifetch_addr = 32'h600;
    cnt = 0;
    while (ord.size() < 3 && cnt < 80) begin
      step;
      cnt++;
      sum = int'(finish_store) + int'(finish_load) + int'(ifetch_done);
      if (sum > 0) chk("prio_one_pulse", 32'(sum), 32'd1);
      if (finish_store) begin ord.push_back(1); lsb_store = 1'b0; end
      if (finish_load)  begin ord.push_back(2); gl = data_load; lsb_load = 1'b0; end
      if (ifetch_done)  begin ord.push_back(3); gf = ifetch_data; ifetch_req = 1'b0; end
    end
    lsb_store = 1'b0; lsb_load = 1'b0; ifetch_req = 1'b0;
    code = 0;
    foreach (ord[i]) code = code * 4 + ord[i];
    chk("prio_order", 32'(code), 32'd27);
    chk("prio_load_data", gl, el);
    chk("prio_fetch_data", gf, ef);
    for (int i = 0; i < 4; i++) model[32'h800 + 32'(i)] = 8'((32'hCAFE_F00D >> (8 * i)) & 32'hFF);
    repeat (2) step;
    do_read(1'b0, 32'h800, 3'b010, 0, 0, "prio_store_readback");

    // Randomised mix over a small window.
    for (int k = 0; k < 20; k++) begin
      a = 32'h1000 + 32'($urandom_range(0, 64));
      d = $urandom;
      case ($urandom_range(0, 2))
        0: do_write(a, 3'($urandom_range(0, 2)), d, 0, 0, 0, 0, "rnd_store");
        1: do_read(1'b0, a, ops[$urandom_range(0, 4)], 0, 0, "rnd_load");
        default: do_read(1'b1, a, 3'b010, 0, 0, "rnd_fetch");
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
